// File: rtl/ncl_sync_bridge.sv
// Clocked bridge from W-bit dual-rail NCL logic into the synchronous domain.
// Rails are synchronised, filtered for stability, and complete DATA words are offered on valid/ready.
`timescale 1ns/1ps

module ncl_sync_bridge #(
    parameter int W             = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 2,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     in_t,
    input  logic [W-1:0]     in_f,
    output logic             ko,
    output logic [W-1:0]     out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       err,
    output logic [CNT_W-1:0] wave_cnt
);

    localparam int STAB_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [STAB_W-1:0] STAB_MAX  = STAB_W'(STABLE_CYCLES);
    localparam logic [STAB_W-1:0] STAB_QUAL = STAB_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_DATA = 2'd0,
        HOLD      = 2'd1,
        WAIT_NULL = 2'd2
    } state_t;

    logic [W-1:0]      sync_t_q [SYNC_STAGES];
    logic [W-1:0]      sync_t_d [SYNC_STAGES];
    logic [W-1:0]      sync_f_q [SYNC_STAGES];
    logic [W-1:0]      sync_f_d [SYNC_STAGES];

    logic [2*W-1:0]    prev_s_q;
    logic [2*W-1:0]    prev_s_d;
    logic [STAB_W-1:0] stab_q;
    logic [STAB_W-1:0] stab_d;

    state_t            state_q;
    state_t            state_d;
    logic              ko_q;
    logic              ko_d;
    logic              out_valid_q;
    logic              out_valid_d;
    logic [W-1:0]      out_data_q;
    logic [W-1:0]      out_data_d;
    logic [1:0]        err_q;
    logic [1:0]        err_d;
    logic [CNT_W-1:0]  wave_cnt_q;
    logic [CNT_W-1:0]  wave_cnt_d;

    logic [W-1:0]      s_t;
    logic [W-1:0]      s_f;
    logic [2*W-1:0]    s;
    logic              all_data;
    logic              all_null;
    logic              illegal;
    logic              qualified;

    always_comb begin
        for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_t_d[i] = (i == 0) ? in_t : sync_t_q[(i == 0) ? 0 : i - 1];
            sync_f_d[i] = (i == 0) ? in_f : sync_f_q[(i == 0) ? 0 : i - 1];
        end
    end

    assign s_t = sync_t_q[SYNC_STAGES-1];
    assign s_f = sync_f_q[SYNC_STAGES-1];
    assign s   = {s_t, s_f};

    assign all_data = &(s_t ^ s_f);
    assign all_null = ~|(s_t | s_f);
    assign illegal  = |(s_t & s_f);

    // stab_d counts how many consecutive cycles s has matched its predecessor, so
    // a value seen for STABLE_CYCLES cycles (including this one) reads STABLE_CYCLES-1.
    always_comb begin
        prev_s_d = s;
        if (s == prev_s_q) begin
            stab_d = (stab_q == STAB_MAX) ? STAB_MAX : stab_q + 1'b1;
        end else begin
            stab_d = '0;
        end
        qualified = (stab_d >= STAB_QUAL) && !illegal;
    end

    always_comb begin
        state_d     = state_q;
        ko_d        = ko_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        err_d       = err_q;
        wave_cnt_d  = wave_cnt_q;

        if (illegal) begin
            err_d[0] = 1'b1;
        end

        case (state_q)
            WAIT_DATA: begin
                if (qualified && all_data) begin
                    out_data_d  = s_t;
                    out_valid_d = 1'b1;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                // The producer must hold its DATA word until ko drops.
                if (s != {out_data_q, ~out_data_q}) begin
                    err_d[1] = 1'b1;
                end
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    ko_d        = 1'b0;
                    state_d     = WAIT_NULL;
                end
            end
            WAIT_NULL: begin
                if (qualified && all_null) begin
                    ko_d       = 1'b1;
                    wave_cnt_d = wave_cnt_q + 1'b1;
                    state_d    = WAIT_DATA;
                end
            end
            default: begin
                state_d = WAIT_DATA;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_t_q[i] <= '0;
                sync_f_q[i] <= '0;
            end
            prev_s_q    <= '0;
            stab_q      <= '0;
            state_q     <= WAIT_DATA;
            ko_q        <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            err_q       <= '0;
            wave_cnt_q  <= '0;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_t_q[i] <= sync_t_d[i];
                sync_f_q[i] <= sync_f_d[i];
            end
            prev_s_q    <= prev_s_d;
            stab_q      <= stab_d;
            state_q     <= state_d;
            ko_q        <= ko_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            err_q       <= err_d;
            wave_cnt_q  <= wave_cnt_d;
        end
    end

    assign ko        = ko_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign err       = err_q;
    assign wave_cnt  = wave_cnt_q;

endmodule

// File: tb/tb_ncl_sync_bridge.sv
// Directed bench for ncl_sync_bridge at W=4 with default parameters.
// Expected values are hand-derived from the NCL handshake and the 4-edge qualification latency.
`timescale 1ns/1ps

module tb_ncl_sync_bridge;

    localparam int W     = 4;
    localparam int CNT_W = 8;

    logic             clk;
    logic             rst;
    logic [W-1:0]     in_t;
    logic [W-1:0]     in_f;
    logic             ko;
    logic [W-1:0]     out_data;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       err;
    logic [CNT_W-1:0] wave_cnt;

    int compared;
    int mismatched;

    ncl_sync_bridge #(
        .W(W),
        .SYNC_STAGES(2),
        .STABLE_CYCLES(2),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_t(in_t),
        .in_f(in_f),
        .ko(ko),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .err(err),
        .wave_cnt(wave_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, leaving time 1ns past the last edge for driving and sampling.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [W-1:0] t, input logic [W-1:0] f);
        in_t = t;
        in_f = f;
    endtask

    task automatic applyData(input logic [W-1:0] v);
        applyStimulus(v, ~v);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        out_ready  = 1'b0;
        applyStimulus(4'h0, 4'h0);
        tick(2);

        checkOutput("reset_ko", 32'(ko), 32'd1);
        checkOutput("reset_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_data", 32'(out_data), 32'd0);
        checkOutput("reset_err", 32'(err), 32'd0);
        checkOutput("reset_cnt", 32'(wave_cnt), 32'd0);

        // Basic DATA 0xA with consumer always ready.
        $display("[TB] basic DATA/NULL cycle");
        rst       = 1'b0;
        out_ready = 1'b1;
        applyData(4'hA);
        tick(3);
        checkOutput("basic_valid_early", 32'(out_valid), 32'd0);
        tick(1);
        checkOutput("basic_valid", 32'(out_valid), 32'd1);
        checkOutput("basic_data", 32'(out_data), 32'hA);
        checkOutput("basic_ko_hold", 32'(ko), 32'd1);
        tick(1);
        checkOutput("basic_ko_fall", 32'(ko), 32'd0);
        checkOutput("basic_valid_drop", 32'(out_valid), 32'd0);
        checkOutput("basic_data_kept", 32'(out_data), 32'hA);
        applyStimulus(4'h0, 4'h0);
        tick(3);
        checkOutput("basic_ko_null_early", 32'(ko), 32'd0);
        tick(1);
        checkOutput("basic_ko_rise", 32'(ko), 32'd1);
        checkOutput("basic_cnt", 32'(wave_cnt), 32'd1);
        checkOutput("basic_err", 32'(err), 32'd0);

        // Consumer back-pressure for 10 cycles.
        $display("[TB] back-pressure");
        out_ready = 1'b0;
        applyData(4'hA);
        tick(4);
        checkOutput("bp_valid", 32'(out_valid), 32'd1);
        tick(10);
        checkOutput("bp_valid_held", 32'(out_valid), 32'd1);
        checkOutput("bp_data_held", 32'(out_data), 32'hA);
        checkOutput("bp_ko_held", 32'(ko), 32'd1);
        out_ready = 1'b1;
        tick(1);
        checkOutput("bp_ko_fall", 32'(ko), 32'd0);
        checkOutput("bp_valid_drop", 32'(out_valid), 32'd0);
        applyStimulus(4'h0, 4'h0);
        tick(4);
        checkOutput("bp_ko_rise", 32'(ko), 32'd1);
        checkOutput("bp_cnt", 32'(wave_cnt), 32'd2);

        // Glitchy producer: partial and DATA 0x5 alternate every cycle, then settle.
        $display("[TB] glitch filter");
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) begin
                applyStimulus(4'b0101, 4'b0010);
            end else begin
                applyData(4'h5);
            end
            tick(1);
            checkOutput("glitch_no_capture", 32'(out_valid), 32'd0);
        end
        applyData(4'h5);
        tick(2);
        checkOutput("glitch_settle_early", 32'(out_valid), 32'd0);
        tick(1);
        checkOutput("glitch_valid", 32'(out_valid), 32'd1);
        checkOutput("glitch_data", 32'(out_data), 32'h5);
        checkOutput("glitch_err", 32'(err), 32'd0);
        tick(1);
        checkOutput("glitch_ko_fall", 32'(ko), 32'd0);
        tick(1);
        checkOutput("glitch_single_capture", 32'(out_valid), 32'd0);
        applyStimulus(4'h0, 4'h0);
        tick(4);
        checkOutput("glitch_cnt", 32'(wave_cnt), 32'd3);

        // Illegal codeword on bit 2 for three cycles while waiting for DATA.
        $display("[TB] illegal codeword");
        applyStimulus(4'b0100, 4'b0100);
        tick(3);
        checkOutput("illegal_err", 32'(err), 32'd1);
        checkOutput("illegal_no_capture", 32'(out_valid), 32'd0);
        applyData(4'h3);
        tick(3);
        checkOutput("illegal_then_early", 32'(out_valid), 32'd0);
        tick(1);
        checkOutput("illegal_then_valid", 32'(out_valid), 32'd1);
        checkOutput("illegal_then_data", 32'(out_data), 32'h3);
        checkOutput("illegal_err_sticky", 32'(err), 32'd1);
        tick(1);
        applyStimulus(4'h0, 4'h0);
        tick(4);
        checkOutput("illegal_cnt", 32'(wave_cnt), 32'd4);

        // Producer changes its word while HOLD is waiting for the consumer.
        $display("[TB] protocol violation");
        out_ready = 1'b0;
        applyData(4'hA);
        tick(4);
        checkOutput("viol_valid", 32'(out_valid), 32'd1);
        applyData(4'hF);
        tick(2);
        checkOutput("viol_err_early", 32'(err), 32'd1);
        tick(1);
        checkOutput("viol_err", 32'(err), 32'd3);
        checkOutput("viol_data_held", 32'(out_data), 32'hA);
        out_ready = 1'b1;
        tick(1);
        checkOutput("viol_ko_fall", 32'(ko), 32'd0);
        applyStimulus(4'h0, 4'h0);
        tick(4);
        checkOutput("viol_ko_rise", 32'(ko), 32'd1);
        checkOutput("viol_cnt", 32'(wave_cnt), 32'd5);

        // Run enough full cycles to wrap the 8-bit wavefront counter.
        $display("[TB] counter wrap");
        for (int i = 0; i < 250; i++) begin
            applyData(4'(i));
            tick(5);
            applyStimulus(4'h0, 4'h0);
            tick(4);
        end
        checkOutput("wrap_cnt_255", 32'(wave_cnt), 32'd255);
        applyData(4'h9);
        tick(4);
        checkOutput("wrap_last_data", 32'(out_data), 32'h9);
        tick(1);
        applyStimulus(4'h0, 4'h0);
        tick(4);
        checkOutput("wrap_cnt_0", 32'(wave_cnt), 32'd0);
        checkOutput("wrap_ko", 32'(ko), 32'd1);

        // Reset while holding a captured word with DATA still on the pins.
        $display("[TB] reset in HOLD");
        out_ready = 1'b0;
        applyData(4'h6);
        tick(4);
        checkOutput("rsthold_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        checkOutput("rsthold_valid_clr", 32'(out_valid), 32'd0);
        checkOutput("rsthold_ko", 32'(ko), 32'd1);
        checkOutput("rsthold_err", 32'(err), 32'd0);
        checkOutput("rsthold_data", 32'(out_data), 32'd0);
        tick(3);
        checkOutput("rsthold_recap_early", 32'(out_valid), 32'd0);
        tick(1);
        checkOutput("rsthold_recap_valid", 32'(out_valid), 32'd1);
        checkOutput("rsthold_recap_data", 32'(out_data), 32'h6);
        checkOutput("rsthold_recap_err", 32'(err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
